uart_reg_fifo: RTL
==================

// Module: uart_reg_fifo
// PURPOSE
//  Second-generation UART register slave on the AXI4 peripheral bus: single-beat reg access, TX/RX FIFOs
//  of parametrised depth between bus and serializer/deserializer, watermark + overrun interrupt to the PLIC.
//  Replaces the unbuffered single-byte TX/RX registers; divider/config outputs feed the existing UART core.
// PARAMETERS
//  REGMAP    32'h0  4 KiB page base; compared against addr[31:12]
//  DATA_W    8      character width (5..9); RX/TX data fields are DATA_W LSBs, rest zero
//  TX_DEPTH  16     TX FIFO entries, power of 2, >=2
//  RX_DEPTH  16     RX FIFO entries, power of 2, >=2
//  CNT_W     $clog2(max(TX_DEPTH,RX_DEPTH))+1  level/watermark width (derived)
// PORTS
//  clk          in   1       system clock
//  rst          in   1       synchronous reset, active-high
//  bus          axi4.slave   register bus (id width bus.idlen; 32-bit data)
//  divider_q_o  out  32      baud divider = f_clk / baud
//  cfg_q_o      out  6       uart config (Config_t: parity/stop/enable bits)
//  tx_d_o       out  DATA_W  TX FIFO head
//  tx_valid_o   out  1       TX FIFO not empty
//  tx_ready_i   in   1       serializer accepts head (pop on valid&ready)
//  rx_d_i       in   DATA_W  received character
//  rx_valid_i   in   1       rx_d_i valid (one-cycle strobe)
//  rx_ready_o   out  1       RX FIFO not full
//  irq_o        out  1       registered |(IRQPEND & IRQMASK)
// BEHAVIOUR
//  Map (offset = addr[11:0]): 0x00 DIVIDER rw | 0x04 TXDATA w(push), r(last pushed) | 0x08 TXSTATUS r
//   {full,empty,level} | 0x0C RXDATA r(pop) | 0x10 RXSTATUS r {full,empty,level} | 0x14 IRQMASK rw[3:0]
//   | 0x18 IRQPEND r, W1C bit3 | 0x1C CONFIG rw {rx_wm[CNT_W-1:0]@[23:16], tx_wm@[15:8], cfg@[5:0]}
//   | 0x20 VERSION r {MAJOR,MINOR,PATCH}. Other offset or page mismatch -> SLVERR, no side effect.
//  Bus FSM IDLE/BRESP/RRESP, all readies/valids combinational from state:
//   IDLE: aw_valid&w_valid -> aw_ready=w_ready=1, write performed this edge, ->BRESP (write wins over read);
//         else ar_valid -> ar_ready=1, read data+resp captured into regs this edge, ->RRESP.
//   BRESP: b_valid=1, b.id=captured aw.id; b_ready -> IDLE. RRESP: r_valid=1, r.last=1, r.id/data/resp held
//   stable from capture; r_ready -> IDLE. Min 2 cycles per access; one outstanding transaction.
//  Registers update only on accepted write; unwritten regs hold (no latch/comb feedback).
//  TXDATA write when TX full -> SLVERR, data dropped, pointers unchanged.
//  RXDATA read when RX empty -> SLVERR, data 0, no pop. Pop occurs at ar handshake.
//  RX push on rx_valid_i&rx_ready_o. rx_valid_i while full -> char dropped, IRQPEND[3] (overrun) set.
//  Same-cycle push+pop: both take effect, level unchanged; legal at full (RX pop frees slot only next cycle:
//   rx_ready_o reflects registered count) and at empty (TX pop requires valid, so no pop at empty).
//  Pointers wrap modulo depth; level = CNT_W bits, range 0..DEPTH.
//  IRQPEND[0]=tx empty, [1]=tx_level<=tx_wm, [2]=rx_level>=rx_wm (rx_wm=0 disables), all level;
//   [3]=overrun sticky, W1C; set wins over simultaneous clear. irq_o registered, 1-cycle lag.
//  Reset (rst at posedge): FIFOs emptied, all regs 0, FSM IDLE, pending response discarded;
//   outputs: readies/valids 0, tx_valid_o 0, rx_ready_o 1, irq_o 0, divider/cfg 0.
// TESTING
//  Write DIVIDER=2604, read back -> 2604 OKAY; write 0x40 -> SLVERR, no reg changes.
//  Push TX_DEPTH+1 bytes tx_ready_i=0 -> first 16 OKAY, 17th SLVERR, TXSTATUS full=1 level=16; release
//   ready -> bytes out in order, empty after 16 pops, IRQPEND[0]=1.
//  Drive 17 RX chars, no reads -> rx_ready_o=0 after 16, IRQPEND[3]=1; read RXDATA x16 in order, 17th SLVERR.
//  IRQMASK=0x4, rx_wm=4: 3 chars -> irq_o=0; 4th -> irq_o=1 next cycle; pop one -> irq_o=0.
//  Same-cycle AW/W and AR -> write served first, read next; overrun set + W1C same cycle -> stays 1.
//  Assert rst during RRESP with FIFOs half full -> r_valid=0 next cycle, levels 0, regs 0.

Source files
------------

// File: rtl/uart_reg_fifo_if.sv
// Single-beat AXI4 register-bus view used by peripheral slaves.
// Carries 32-bit addresses and data, and ID_W-bit transaction IDs.
interface axi4 #(
  parameter int ID_W = 4
);
  logic            aw_valid;
  logic            aw_ready;
  logic [31:0]     aw_addr;
  logic [ID_W-1:0] aw_id;
  logic            w_valid;
  logic            w_ready;
  logic [31:0]     w_data;
  logic            b_valid;
  logic            b_ready;
  logic [ID_W-1:0] b_id;
  logic [1:0]      b_resp;
  logic            ar_valid;
  logic            ar_ready;
  logic [31:0]     ar_addr;
  logic [ID_W-1:0] ar_id;
  logic            r_valid;
  logic            r_ready;
  logic [31:0]     r_data;
  logic [1:0]      r_resp;
  logic [ID_W-1:0] r_id;
  logic            r_last;

  modport slave (
    input  aw_valid, aw_addr, aw_id, w_valid, w_data, b_ready,
           ar_valid, ar_addr, ar_id, r_ready,
    output aw_ready, w_ready, b_valid, b_id, b_resp,
           ar_ready, r_valid, r_data, r_resp, r_id, r_last
  );

  modport master (
    output aw_valid, aw_addr, aw_id, w_valid, w_data, b_ready,
           ar_valid, ar_addr, ar_id, r_ready,
    input  aw_ready, w_ready, b_valid, b_id, b_resp,
           ar_ready, r_valid, r_data, r_resp, r_id, r_last
  );
endinterface

// File: rtl/uart_reg_fifo.sv
// UART register slave: AXI4 single-beat register access, TX/RX character FIFOs,
// and watermark/overrun interrupt generation.
module uart_reg_fifo #(
  parameter logic [31:0] REGMAP   = 32'h0,
  parameter int          DATA_W   = 8,
  parameter int          TX_DEPTH = 16,
  parameter int          RX_DEPTH = 16,
  parameter int          ID_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  axi4.slave                bus,
  output logic [31:0]       divider_q_o,
  output logic [5:0]        cfg_q_o,
  output logic [DATA_W-1:0] tx_d_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  input  logic [DATA_W-1:0] rx_d_i,
  input  logic              rx_valid_i,
  output logic              rx_ready_o,
  output logic              irq_o
);
  localparam int CNT_W = $clog2((TX_DEPTH > RX_DEPTH) ? TX_DEPTH : RX_DEPTH) + 1;
  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam logic [CNT_W-1:0] TX_FULL = CNT_W'(TX_DEPTH);
  localparam logic [CNT_W-1:0] RX_FULL = CNT_W'(RX_DEPTH);
  localparam logic [31:0] VERSION = 32'h0002_0000;
  localparam logic [1:0]  OKAY    = 2'b00;
  localparam logic [1:0]  SLVERR  = 2'b10;
  localparam logic [11:0] A_DIV = 12'h000, A_TXD = 12'h004, A_TXS = 12'h008,
                          A_RXD = 12'h00C, A_RXS = 12'h010, A_MASK = 12'h014,
                          A_PEND = 12'h018, A_CFG = 12'h01C, A_VER = 12'h020;

  typedef enum logic [1:0] {IDLE, BRESP, RRESP} state_t;
  state_t state;

  logic [ID_W-1:0]   b_id_q, r_id_q;
  logic [1:0]        b_resp_q, r_resp_q;
  logic [31:0]       r_data_q;
  logic [31:0]       divider_q;
  logic [5:0]        cfg_q;
  logic [DATA_W-1:0] tx_last;
  logic [3:0]        irq_mask;
  logic              overrun;
  logic              irq_q;
  logic [CNT_W-1:0]  tx_wm, rx_wm;

  logic [DATA_W-1:0] tx_mem [TX_DEPTH];
  logic [DATA_W-1:0] rx_mem [RX_DEPTH];
  logic [TX_AW-1:0]  tx_wr, tx_rd;
  logic [RX_AW-1:0]  rx_wr, rx_rd;
  logic [CNT_W-1:0]  tx_cnt, rx_cnt;

  logic tx_full, tx_empty, rx_empty, tx_push, tx_pop, rx_push, rx_pop, rx_overrun;
  logic wr_hs, rd_hs, wr_ok;
  logic [1:0]  wr_resp, rd_resp;
  logic [31:0] rd_data;
  logic [3:0]  irq_pend;
  logic [11:0] wr_off, rd_off;

  assign tx_full    = (tx_cnt == TX_FULL);
  assign tx_empty   = (tx_cnt == '0);
  assign rx_empty   = (rx_cnt == '0);
  assign rx_ready_o = (rx_cnt != RX_FULL);
  assign tx_valid_o = ~tx_empty;
  assign tx_d_o     = tx_mem[tx_rd];
  assign tx_pop     = tx_valid_o & tx_ready_i;
  assign rx_push    = rx_valid_i & rx_ready_o;
  assign rx_overrun = rx_valid_i & ~rx_ready_o;
  assign irq_pend   = {overrun, (rx_wm != '0) && (rx_cnt >= rx_wm), tx_cnt <= tx_wm, tx_empty};

  // A complete write request always wins the IDLE slot over a pending read.
  assign wr_hs        = (state == IDLE) & bus.aw_valid & bus.w_valid & ~rst;
  assign rd_hs        = (state == IDLE) & ~(bus.aw_valid & bus.w_valid) & bus.ar_valid & ~rst;
  assign bus.aw_ready = wr_hs;
  assign bus.w_ready  = wr_hs;
  assign bus.ar_ready = rd_hs;
  assign bus.b_valid  = (state == BRESP);
  assign bus.b_id     = b_id_q;
  assign bus.b_resp   = b_resp_q;
  assign bus.r_valid  = (state == RRESP);
  assign bus.r_id     = r_id_q;
  assign bus.r_data   = r_data_q;
  assign bus.r_resp   = r_resp_q;
  assign bus.r_last   = 1'b1;

  assign divider_q_o = divider_q;
  assign cfg_q_o     = cfg_q;
  assign irq_o       = irq_q;
  assign wr_off      = bus.aw_addr[11:0];
  assign rd_off      = bus.ar_addr[11:0];
  assign wr_ok       = wr_hs & (wr_resp == OKAY);

  always_comb begin
    wr_resp = OKAY;
    tx_push = 1'b0;
    if (bus.aw_addr[31:12] != REGMAP[31:12]) wr_resp = SLVERR;
    else begin
      case (wr_off)
        A_DIV, A_TXS, A_RXD, A_RXS, A_MASK, A_PEND, A_CFG, A_VER: ;
        A_TXD: if (tx_full) wr_resp = SLVERR;
               else tx_push = wr_hs;
        default: wr_resp = SLVERR;
      endcase
    end
  end

  always_comb begin
    rd_data = '0;
    rd_resp = OKAY;
    rx_pop  = 1'b0;
    if (bus.ar_addr[31:12] != REGMAP[31:12]) rd_resp = SLVERR;
    else begin
      case (rd_off)
        A_DIV:  rd_data = divider_q;
        A_TXD:  rd_data = 32'(tx_last);
        A_TXS:  rd_data = 32'({tx_full, tx_empty, tx_cnt});
        A_RXD:  if (rx_empty) rd_resp = SLVERR;
                else begin
                  rd_data = 32'(rx_mem[rx_rd]);
                  rx_pop  = rd_hs;
                end
        A_RXS:  rd_data = 32'({~rx_ready_o, rx_empty, rx_cnt});
        A_MASK: rd_data = 32'(irq_mask);
        A_PEND: rd_data = 32'(irq_pend);
        A_CFG: begin
          rd_data[16 +: CNT_W] = rx_wm;
          rd_data[8 +: CNT_W]  = tx_wm;
          rd_data[5:0]         = cfg_q;
        end
        A_VER:  rd_data = VERSION;
        default: rd_resp = SLVERR;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr] <= bus.w_data[DATA_W-1:0];
    if (rx_push) rx_mem[rx_wr] <= rx_d_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      b_id_q    <= '0;
      b_resp_q  <= OKAY;
      r_id_q    <= '0;
      r_resp_q  <= OKAY;
      r_data_q  <= '0;
      divider_q <= '0;
      cfg_q     <= '0;
      tx_last   <= '0;
      irq_mask  <= '0;
      overrun   <= 1'b0;
      irq_q     <= 1'b0;
      tx_wm     <= '0;
      rx_wm     <= '0;
      tx_wr     <= '0;
      tx_rd     <= '0;
      tx_cnt    <= '0;
      rx_wr     <= '0;
      rx_rd     <= '0;
      rx_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (wr_hs) begin
            b_id_q   <= bus.aw_id;
            b_resp_q <= wr_resp;
            state    <= BRESP;
          end else if (rd_hs) begin
            r_id_q   <= bus.ar_id;
            r_data_q <= rd_data;
            r_resp_q <= rd_resp;
            state    <= RRESP;
          end
        end
        BRESP:   if (bus.b_ready) state <= IDLE;
        RRESP:   if (bus.r_ready) state <= IDLE;
        default: state <= IDLE;
      endcase

      if (wr_ok) begin
        case (wr_off)
          A_DIV:  divider_q <= bus.w_data;
          A_TXD:  tx_last   <= bus.w_data[DATA_W-1:0];
          A_MASK: irq_mask  <= bus.w_data[3:0];
          A_CFG: begin
            rx_wm <= bus.w_data[16 +: CNT_W];
            tx_wm <= bus.w_data[8 +: CNT_W];
            cfg_q <= bus.w_data[5:0];
          end
          default: ;
        endcase
      end

      // A new overrun in the same cycle as its W1C keeps the flag set.
      if (rx_overrun) overrun <= 1'b1;
      else if (wr_ok && wr_off == A_PEND && bus.w_data[3]) overrun <= 1'b0;

      if (tx_push) tx_wr <= tx_wr + 1'b1;
      if (tx_pop)  tx_rd <= tx_rd + 1'b1;
      tx_cnt <= tx_cnt + {{(CNT_W-1){1'b0}}, tx_push} - {{(CNT_W-1){1'b0}}, tx_pop};
      if (rx_push) rx_wr <= rx_wr + 1'b1;
      if (rx_pop)  rx_rd <= rx_rd + 1'b1;
      rx_cnt <= rx_cnt + {{(CNT_W-1){1'b0}}, rx_push} - {{(CNT_W-1){1'b0}}, rx_pop};

      irq_q <= |(irq_pend & irq_mask);
    end
  end
endmodule
